// File: rtl/cic_dec_ctrl.sv
// Control sequencer for a CIC decimator: flush/warm-up/run phasing, ratio reload, output handshake.
// Define CIC_DEC_CTRL_DCLK_EN to build the output-rate clock d_clk; otherwise d_clk is tied low.
module cic_dec_ctrl #(
  parameter int RATIO_W     = 16,
  parameter int N_STAGES    = 5,
  parameter int RESET_RATIO = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [RATIO_W-1:0] cfg_ratio,
  input  logic               cfg_wr,
  output logic [RATIO_W-1:0] cur_ratio,
  output logic               cfg_pend,
  output logic               dec_strobe,
  output logic               comb_en,
  output logic               integ_clr,
  output logic               d_clk,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               overflow
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_WARMUP,
    ST_RUN
  } state_e;

  localparam logic [RATIO_W-1:0] MIN_RATIO = RATIO_W'(2);
  localparam logic [RATIO_W-1:0] RST_RATIO = RATIO_W'(RESET_RATIO);
  localparam logic [3:0]         WU_LAST   = 4'(N_STAGES - 1);

  state_e             state_q, state_d;
  logic [RATIO_W-1:0] cnt_q, cnt_d;
  logic [RATIO_W-1:0] cur_ratio_q, cur_ratio_d;
  logic [RATIO_W-1:0] pend_ratio_q, pend_ratio_d;
  logic               cfg_pend_q, cfg_pend_d;
  logic               dec_strobe_q, dec_strobe_d;
  logic               comb_en_q, comb_en_d;
  logic               integ_clr_q, integ_clr_d;
  logic [3:0]         wu_cnt_q, wu_cnt_d;
  logic               out_valid_q, out_valid_d;
  logic               overflow_q, overflow_d;

  logic apply;
  logic active_q;
  logic active_d;
  logic set_valid;

  // A pending ratio is taken immediately when idle, otherwise only at a decimation boundary.
  assign apply    = cfg_pend_q && ((state_q == ST_IDLE) || dec_strobe_q);
  assign active_q = (state_q == ST_WARMUP) || (state_q == ST_RUN);
  assign active_d = (state_d == ST_WARMUP) || (state_d == ST_RUN);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path through this block can infer a latch.
    state_d = state_q;
    if (!en) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:   state_d = ST_FLUSH;
        ST_FLUSH:  state_d = ST_WARMUP;
        ST_WARMUP: begin
          if (apply)                                state_d = ST_FLUSH;
          else if (comb_en_q && wu_cnt_q == WU_LAST) state_d = ST_RUN;
        end
        ST_RUN:    if (apply) state_d = ST_FLUSH;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Output and datapath next values; every control output is registered.
  always_comb begin
    set_valid   = comb_en_q && (state_q == ST_RUN);
    cur_ratio_d = apply ? pend_ratio_q : cur_ratio_q;

    pend_ratio_d = pend_ratio_q;
    cfg_pend_d   = cfg_pend_q && !apply;
    if (cfg_wr) begin
      pend_ratio_d = (cfg_ratio < MIN_RATIO) ? MIN_RATIO : cfg_ratio;
      cfg_pend_d   = 1'b1;
    end

    cnt_d = '0;
    if (active_d && active_q) begin
      cnt_d = (cnt_q == cur_ratio_q - RATIO_W'(1)) ? '0 : cnt_q + RATIO_W'(1);
    end

    dec_strobe_d = active_d && (cnt_d == cur_ratio_d - RATIO_W'(1));
    comb_en_d    = dec_strobe_q;
    integ_clr_d  = (state_d == ST_FLUSH);

    wu_cnt_d = '0;
    if (state_q == ST_WARMUP) begin
      wu_cnt_d = comb_en_q ? wu_cnt_q + 4'd1 : wu_cnt_q;
    end

    out_valid_d = out_valid_q;
    if ((state_d == ST_IDLE) || (state_d == ST_FLUSH)) begin
      out_valid_d = 1'b0;
    end else if (set_valid) begin
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    overflow_d = overflow_q || (set_valid && out_valid_q && !out_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      cur_ratio_q  <= RST_RATIO;
      pend_ratio_q <= RST_RATIO;
      cfg_pend_q   <= 1'b0;
      dec_strobe_q <= 1'b0;
      comb_en_q    <= 1'b0;
      integ_clr_q  <= 1'b0;
      wu_cnt_q     <= '0;
      out_valid_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      cur_ratio_q  <= cur_ratio_d;
      pend_ratio_q <= pend_ratio_d;
      cfg_pend_q   <= cfg_pend_d;
      dec_strobe_q <= dec_strobe_d;
      comb_en_q    <= comb_en_d;
      integ_clr_q  <= integ_clr_d;
      wu_cnt_q     <= wu_cnt_d;
      out_valid_q  <= out_valid_d;
      overflow_q   <= overflow_d;
    end
  end

`ifdef CIC_DEC_CTRL_DCLK_EN
  logic d_clk_q, d_clk_d;

  // High from the comb_en edge until the edge after the half-period count.
  always_comb begin
    d_clk_d = d_clk_q;
    if ((state_d == ST_IDLE) || (state_d == ST_FLUSH)) begin
      d_clk_d = 1'b0;
    end else if (dec_strobe_q) begin
      d_clk_d = 1'b1;
    end else if (cnt_q == (cur_ratio_q >> 1)) begin
      d_clk_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_clk_q <= 1'b0;
    else     d_clk_q <= d_clk_d;
  end

  assign d_clk = d_clk_q;
`else
  assign d_clk = 1'b0;
`endif

  assign cur_ratio  = cur_ratio_q;
  assign cfg_pend   = cfg_pend_q;
  assign dec_strobe = dec_strobe_q;
  assign comb_en    = comb_en_q;
  assign integ_clr  = integ_clr_q;
  assign out_valid  = out_valid_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_cic_dec_ctrl.sv
// Scoreboard bench for cic_dec_ctrl: expected strobe, clear and sample cycles are queued as
// stimulus is applied and matched by a negedge monitor; CIC_DEC_CTRL_DCLK_EN selects d_clk expectations.
module tb_cic_dec_ctrl;

`ifdef CIC_DEC_CTRL_DCLK_EN
  localparam bit DCLK_ON = 1'b1;
`else
  localparam bit DCLK_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] cfg_ratio;
  logic        cfg_wr;
  logic [15:0] cur_ratio;
  logic        cfg_pend;
  logic        dec_strobe;
  logic        comb_en;
  logic        integ_clr;
  logic        d_clk;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int strobe_q[$];
  int clr_q[$];
  int vset_q[$];
  logic strobe_prev = 1'b0;
  logic valid_prev  = 1'b0;

  cic_dec_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .cfg_ratio  (cfg_ratio),
    .cfg_wr     (cfg_wr),
    .cur_ratio  (cur_ratio),
    .cfg_pend   (cfg_pend),
    .dec_strobe (dec_strobe),
    .comb_en    (comb_en),
    .integ_clr  (integ_clr),
    .d_clk      (d_clk),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic push_strobes(input int first, input int r, input int n);
    for (int k = 0; k < n; k++) strobe_q.push_back(first + k * r);
  endtask

  task automatic cfg_write(input int v);
    cfg_ratio = 16'(v);
    cfg_wr    = 1'b1;
    @(negedge clk);
    cfg_wr    = 1'b0;
  endtask

  task automatic check_drained();
    check("strobe_left", strobe_q.size(), 0);
    check("clr_left", clr_q.size(), 0);
    check("vset_left", vset_q.size(), 0);
  endtask

  // Monitor: pops the expected cycle of every strobe, clear pulse and out_valid rise.
  always @(negedge clk) begin
    if (!rst) begin
      if (dec_strobe) begin
        if (strobe_q.size() == 0) check("strobe_unexpected", cyc, -1);
        else check("strobe_cycle", cyc, strobe_q.pop_front());
      end
      if (integ_clr) begin
        if (clr_q.size() == 0) check("clr_unexpected", cyc, -1);
        else check("clr_cycle", cyc, clr_q.pop_front());
      end
      if (out_valid && !valid_prev) begin
        if (vset_q.size() == 0) check("vset_unexpected", cyc, -1);
        else check("vset_cycle", cyc, vset_q.pop_front());
      end
      if (comb_en || strobe_prev) check("comb_en_delay", int'(comb_en), int'(strobe_prev));
    end
    strobe_prev = dec_strobe;
    valid_prev  = out_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int b;
    int r;
    rst       = 1'b1;
    en        = 1'b0;
    cfg_wr    = 1'b0;
    cfg_ratio = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_cur_ratio", int'(cur_ratio), 64);
    check("rst_cfg_pend", int'(cfg_pend), 0);
    check("rst_dec_strobe", int'(dec_strobe), 0);
    check("rst_comb_en", int'(comb_en), 0);
    check("rst_integ_clr", int'(integ_clr), 0);
    check("rst_d_clk", int'(d_clk), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_overflow", int'(overflow), 0);

    // Start-up at the reset ratio of 64.
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    b   = cyc;
    clr_q.push_back(b + 1);
    push_strobes(b + 65, 64, 7);
    vset_q.push_back(b + 387);
    vset_q.push_back(b + 451);
    wait_cyc(b + 460);
    check("s1_overflow", int'(overflow), 0);
    en = 1'b0;
    @(negedge clk);
    check("s1_idle_valid", int'(out_valid), 0);
    check_drained();

    // Ratio 8, change to 16 mid-run, then a write coincident with application.
    cfg_write(8);
    check("s2_pend_idle", int'(cfg_pend), 1);
    @(negedge clk);
    check("s2_cur8", int'(cur_ratio), 8);
    check("s2_pend_clr", int'(cfg_pend), 0);
    b  = cyc;
    en = 1'b1;
    clr_q.push_back(b + 1);
    clr_q.push_back(b + 58);
    clr_q.push_back(b + 171);
    clr_q.push_back(b + 184);
    push_strobes(b + 9, 8, 7);
    push_strobes(b + 74, 16, 7);
    strobe_q.push_back(b + 183);
    push_strobes(b + 192, 8, 2);
    vset_q.push_back(b + 51);
    vset_q.push_back(b + 156);
    wait_cyc(b + 53);
    cfg_ratio = 16'd16;
    cfg_wr    = 1'b1;
    @(negedge clk);
    cfg_wr = 1'b0;
    check("s2_pend_run", int'(cfg_pend), 1);
    check("s2_cur_hold", int'(cur_ratio), 8);
    wait_cyc(b + 57);
    check("s2_pend_at_strobe", int'(cfg_pend), 1);
    wait_cyc(b + 58);
    check("s2_cur16", int'(cur_ratio), 16);
    check("s2_pend_applied", int'(cfg_pend), 0);
    wait_cyc(b + 159);
    cfg_ratio = 16'd12;
    cfg_wr    = 1'b1;
    @(negedge clk);
    cfg_wr = 1'b0;
    check("s2_pend12", int'(cfg_pend), 1);
    wait_cyc(b + 170);
    cfg_ratio = 16'd8;
    cfg_wr    = 1'b1;
    @(negedge clk);
    cfg_wr = 1'b0;
    check("s2_cur12", int'(cur_ratio), 12);
    check("s2_pend_coincident", int'(cfg_pend), 1);
    wait_cyc(b + 184);
    check("s2_cur8_again", int'(cur_ratio), 8);
    check("s2_pend_final", int'(cfg_pend), 0);
    wait_cyc(b + 203);
    en = 1'b0;
    @(negedge clk);
    check("s2_idle_valid", int'(out_valid), 0);
    check_drained();

    // Ratios below 2 clamp to 2.
    cfg_write(0);
    @(negedge clk);
    check("s3_clamp0", int'(cur_ratio), 2);
    cfg_write(7);
    @(negedge clk);
    check("s3_cur7", int'(cur_ratio), 7);
    cfg_write(1);
    @(negedge clk);
    check("s3_clamp1", int'(cur_ratio), 2);
    b  = cyc;
    en = 1'b1;
    clr_q.push_back(b + 1);
    push_strobes(b + 3, 2, 10);
    for (int k = 0; k < 4; k++) vset_q.push_back(b + 15 + 2 * k);
    wait_cyc(b + 22);
    en = 1'b0;
    @(negedge clk);
    check("s3_idle_valid", int'(out_valid), 0);
    check_drained();

    // Back-pressure at ratio 4, then drop en while a sample is held.
    cfg_write(4);
    @(negedge clk);
    check("s4_cur4", int'(cur_ratio), 4);
    out_ready = 1'b0;
    b  = cyc;
    en = 1'b1;
    clr_q.push_back(b + 1);
    push_strobes(b + 5, 4, 10);
    vset_q.push_back(b + 27);
    vset_q.push_back(b + 43);
    wait_cyc(b + 30);
    check("s4_valid_held", int'(out_valid), 1);
    check("s4_no_ovf_stall", int'(overflow), 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("s4_valid_coincident", int'(out_valid), 1);
    check("s4_no_ovf_coincident", int'(overflow), 0);
    wait_cyc(b + 34);
    check("s4_no_ovf_before", int'(overflow), 0);
    @(negedge clk);
    check("s4_ovf_set", int'(overflow), 1);
    check("s4_valid_ovf", int'(out_valid), 1);
    wait_cyc(b + 40);
    check("s4_ovf_sticky", int'(overflow), 1);
    check("s4_valid_stall", int'(out_valid), 1);
    wait_cyc(b + 41);
    out_ready = 1'b1;
    @(negedge clk);
    check("s4_valid_consumed", int'(out_valid), 0);
    @(negedge clk);
    check("s4_valid_new", int'(out_valid), 1);
    out_ready = 1'b0;
    en        = 1'b0;
    @(negedge clk);
    check("s4_en_drop_valid", int'(out_valid), 0);
    check("s4_ovf_idle", int'(overflow), 1);
    check_drained();

    // Asynchronous reset mid-warm-up with a ratio pending.
    out_ready = 1'b1;
    b  = cyc;
    en = 1'b1;
    clr_q.push_back(b + 1);
    push_strobes(b + 5, 4, 3);
    wait_cyc(b + 10);
    cfg_ratio = 16'd9;
    cfg_wr    = 1'b1;
    @(negedge clk);
    cfg_wr = 1'b0;
    check("s5_pend", int'(cfg_pend), 1);
    wait_cyc(b + 13);
    check("s5_strobe_pre", int'(dec_strobe), 1);
    #1 rst = 1'b1;
    #1;
    check("s5_rst_cur", int'(cur_ratio), 64);
    check("s5_rst_pend", int'(cfg_pend), 0);
    check("s5_rst_strobe", int'(dec_strobe), 0);
    check("s5_rst_comb_en", int'(comb_en), 0);
    check("s5_rst_integ_clr", int'(integ_clr), 0);
    check("s5_rst_d_clk", int'(d_clk), 0);
    check("s5_rst_valid", int'(out_valid), 0);
    check("s5_rst_ovf", int'(overflow), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    r   = cyc;
    clr_q.push_back(r + 1);
    @(negedge clk);
    check("s5_restart_cur", int'(cur_ratio), 64);
    check("s5_restart_pend", int'(cfg_pend), 0);
    wait_cyc(r + 3);
    en = 1'b0;
    @(negedge clk);
    check_drained();

    // Output-rate clock at ratio 10.
    cfg_write(10);
    @(negedge clk);
    check("s6_cur10", int'(cur_ratio), 10);
    b  = cyc;
    en = 1'b1;
    clr_q.push_back(b + 1);
    push_strobes(b + 11, 10, 3);
    wait_cyc(b + 12);
    for (int i = 0; i < 20; i++) begin
      int exp_dclk;
      exp_dclk = (DCLK_ON && (((cyc - b - 2) % 10) < 6)) ? 1 : 0;
      check("d_clk_phase", int'(d_clk), exp_dclk);
      @(negedge clk);
    end
    wait_cyc(b + 33);
    en = 1'b0;
    @(negedge clk);
    check("s6_idle_d_clk", int'(d_clk), 0);
    check_drained();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
